// File: rtl/axi_lite_dram_responder.sv
// AXI4-Lite-style slave memory acting as a DRAM model with configurable response latency.
// One transaction is in flight at a time. Reads take priority over writes in IDLE.
//
// Ports:
//   clk, rst              system clock, synchronous active-high reset
//   ar_valid/ar_addr/ar_ready          read address channel
//   r_valid/r_data/r_resp/r_ready      read data channel (resp 00 OKAY, 10 SLVERR)
//   aw_valid/aw_addr/aw_ready          write address channel
//   w_valid/w_data/w_ready             write data channel
//   b_valid/b_resp/b_ready             write response channel
//
// Latency: the response valid rises LAT+1 clock edges after the edge that completes the
// AR (read) or W (write) handshake.
module axi_lite_dram_responder #(
  parameter int unsigned           ADDR_W    = 17,
  parameter int unsigned           DATA_W    = 64,
  parameter logic [ADDR_W-1:0]     BASE_ADDR = 17'h10000,
  parameter int unsigned           DEPTH     = 256,
  parameter int unsigned           LAT       = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ar_valid,
  input  logic [ADDR_W-1:0] ar_addr,
  output logic              ar_ready,
  output logic              r_valid,
  output logic [DATA_W-1:0] r_data,
  output logic [1:0]        r_resp,
  input  logic              r_ready,
  input  logic              aw_valid,
  input  logic [ADDR_W-1:0] aw_addr,
  output logic              aw_ready,
  input  logic              w_valid,
  input  logic [DATA_W-1:0] w_data,
  output logic              w_ready,
  output logic              b_valid,
  output logic [1:0]        b_resp,
  input  logic              b_ready
);

  localparam int unsigned IdxW = $clog2(DEPTH);
  localparam int unsigned AddrW1 = ADDR_W + 1;
  // One extra bit so the upper bound cannot wrap.
  localparam logic [ADDR_W:0] AddrLo = {1'b0, BASE_ADDR};
  localparam logic [ADDR_W:0] AddrHi = AddrLo + AddrW1'(DEPTH * 8);
  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlvErr = 2'b10;

  typedef enum logic [2:0] {
    Idle,
    RdWait,
    RdResp,
    WrData,
    WrWait,
    WrResp
  } state_t;

  state_t            state;
  logic [3:0]        cnt;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] offset;
  logic [IdxW-1:0]   idx;
  logic              addr_ok;

  logic [DATA_W-1:0] mem [DEPTH];

  // Decode of the latched address.
  always_comb begin
    offset  = addr - BASE_ADDR;
    idx     = IdxW'(offset >> 3);
    addr_ok = ({1'b0, addr} >= AddrLo) && ({1'b0, addr} < AddrHi) && (addr[2:0] == 3'b000);
  end

  assign ar_ready = (state == Idle) && !rst;
  // A read in the same cycle wins; the write stays pending.
  assign aw_ready = (state == Idle) && !ar_valid && !rst;

  // Memory is not reset; a write commits on the W handshake edge.
  always_ff @(posedge clk) begin
    if (!rst && w_valid && w_ready && addr_ok) begin
      mem[idx] <= w_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= Idle;
      cnt     <= 4'd0;
      r_valid <= 1'b0;
      r_data  <= '0;
      r_resp  <= RespOkay;
      b_valid <= 1'b0;
      b_resp  <= RespOkay;
      w_ready <= 1'b0;
    end else begin
      unique case (state)
        Idle: begin
          if (ar_valid) begin
            addr  <= ar_addr;
            cnt   <= 4'(LAT);
            state <= RdWait;
          end else if (aw_valid) begin
            addr    <= aw_addr;
            w_ready <= 1'b1;
            state   <= WrData;
          end
        end
        RdWait: begin
          if (cnt == 4'd0) begin
            r_valid <= 1'b1;
            r_data  <= addr_ok ? mem[idx] : '0;
            r_resp  <= addr_ok ? RespOkay : RespSlvErr;
            state   <= RdResp;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RdResp: begin
          if (r_ready) begin
            r_valid <= 1'b0;
            state   <= Idle;
          end
        end
        WrData: begin
          if (w_valid) begin
            w_ready <= 1'b0;
            cnt     <= 4'(LAT);
            state   <= WrWait;
          end
        end
        WrWait: begin
          if (cnt == 4'd0) begin
            b_valid <= 1'b1;
            b_resp  <= addr_ok ? RespOkay : RespSlvErr;
            state   <= WrResp;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        WrResp: begin
          if (b_ready) begin
            b_valid <= 1'b0;
            state   <= Idle;
          end
        end
        default: state <= Idle;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_lite_dram_responder.sv
// Scoreboard bench for axi_lite_dram_responder: stimulus pushes expected responses,
// a negedge monitor pops and compares on each R/B handshake and checks latency and hold.
module tb_axi_lite_dram_responder;

  localparam int LAT = 4;

  typedef struct {
    logic [63:0] d;
    logic [1:0]  resp;
  } r_exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ar_valid = 1'b0, ar_ready;
  logic [16:0] ar_addr = '0;
  logic        r_valid, r_ready = 1'b0;
  logic [63:0] r_data;
  logic [1:0]  r_resp;
  logic        aw_valid = 1'b0, aw_ready;
  logic [16:0] aw_addr = '0;
  logic        w_valid = 1'b0, w_ready;
  logic [63:0] w_data = '0;
  logic        b_valid, b_ready = 1'b0;
  logic [1:0]  b_resp;

  // LAT=0 instance
  logic        z_ar_valid = 1'b0, z_ar_ready;
  logic [16:0] z_ar_addr = '0;
  logic        z_r_valid, z_r_ready = 1'b0;
  logic [63:0] z_r_data;
  logic [1:0]  z_r_resp;
  logic        z_aw_valid = 1'b0, z_aw_ready;
  logic [16:0] z_aw_addr = '0;
  logic        z_w_valid = 1'b0, z_w_ready;
  logic [63:0] z_w_data = '0;
  logic        z_b_valid, z_b_ready = 1'b0;
  logic [1:0]  z_b_resp;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  r_exp_t      exp_r[$];
  logic [1:0]  exp_b[$];

  axi_lite_dram_responder #(.LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .ar_valid(ar_valid), .ar_addr(ar_addr), .ar_ready(ar_ready),
    .r_valid(r_valid), .r_data(r_data), .r_resp(r_resp), .r_ready(r_ready),
    .aw_valid(aw_valid), .aw_addr(aw_addr), .aw_ready(aw_ready),
    .w_valid(w_valid), .w_data(w_data), .w_ready(w_ready),
    .b_valid(b_valid), .b_resp(b_resp), .b_ready(b_ready)
  );

  axi_lite_dram_responder #(.LAT(0)) u0 (
    .clk(clk), .rst(rst),
    .ar_valid(z_ar_valid), .ar_addr(z_ar_addr), .ar_ready(z_ar_ready),
    .r_valid(z_r_valid), .r_data(z_r_data), .r_resp(z_r_resp), .r_ready(z_r_ready),
    .aw_valid(z_aw_valid), .aw_addr(z_aw_addr), .aw_ready(z_aw_ready),
    .w_valid(z_w_valid), .w_data(z_w_data), .w_ready(z_w_ready),
    .b_valid(z_b_valid), .b_resp(z_b_resp), .b_ready(z_b_ready)
  );

  initial forever #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic sig(input int s);
    case (s)
      0: return aw_ready;
      1: return w_ready;
      2: return ar_ready;
      3: return r_valid;
      default: return b_valid;
    endcase
  endfunction

  // Waits (bounded) for a negedge where the selected signal is high.
  task automatic wait_on(input int s, input string name);
    int n = 0;
    @(negedge clk);
    while (!sig(s) && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk(name, 64'(sig(s)), 64'd1);
  endtask

  task automatic wr(input logic [16:0] a, input logic [63:0] d, input logic [1:0] resp,
                    input int bp);
    exp_b.push_back(resp);
    aw_valid = 1'b1;
    aw_addr  = a;
    wait_on(0, "aw_ready");
    @(posedge clk); #1;
    aw_valid = 1'b0;
    w_valid  = 1'b1;
    w_data   = d;
    wait_on(1, "w_ready");
    @(posedge clk); #1;
    w_valid = 1'b0;
    wait_on(4, "b_valid");
    @(posedge clk); #1;
    if (bp > 0) begin
      repeat (bp) @(posedge clk);
      #1;
      chk("b_bp_valid", 64'(b_valid), 64'd1);
      chk("b_bp_aw_ready", 64'(aw_ready), 64'd0);
    end
    b_ready = 1'b1;
    @(posedge clk); #1;
    b_ready = 1'b0;
  endtask

  task automatic rd(input logic [16:0] a, input logic [63:0] d, input logic [1:0] resp,
                    input int bp);
    r_exp_t e;
    e.d = d;
    e.resp = resp;
    exp_r.push_back(e);
    ar_valid = 1'b1;
    ar_addr  = a;
    wait_on(2, "ar_ready");
    @(posedge clk); #1;
    ar_valid = 1'b0;
    wait_on(3, "r_valid");
    @(posedge clk); #1;
    if (bp > 0) begin
      repeat (bp) @(posedge clk);
      #1;
      chk("r_bp_valid", 64'(r_valid), 64'd1);
      chk("r_bp_ar_ready", 64'(ar_ready), 64'd0);
    end
    r_ready = 1'b1;
    @(posedge clk); #1;
    r_ready = 1'b0;
  endtask

  // Monitor: latency from handshake edge, stability while stalled, scoreboard compare.
  initial begin
    int ar_hs = 0, w_hs = 0;
    logic r_prev = 1'b0, b_prev = 1'b0;
    logic [63:0] r_hold = '0;
    logic [1:0] rr_hold = '0, b_hold = '0;
    r_exp_t e;
    logic [1:0] eb;
    forever begin
      @(negedge clk);
      if (rst) begin
        r_prev = 1'b0;
        b_prev = 1'b0;
      end else begin
        if (ar_valid && ar_ready) ar_hs = cyc + 1;
        if (w_valid && w_ready) w_hs = cyc + 1;
        if (r_valid && !r_prev) begin
          chk("r_latency", 64'(cyc - ar_hs), 64'(LAT + 1));
          r_hold = r_data;
          rr_hold = r_resp;
        end else if (r_valid) begin
          chk("r_hold_data", r_data, r_hold);
          chk("r_hold_resp", 64'(r_resp), 64'(rr_hold));
        end
        if (b_valid && !b_prev) begin
          chk("b_latency", 64'(cyc - w_hs), 64'(LAT + 1));
          b_hold = b_resp;
        end else if (b_valid) begin
          chk("b_hold_resp", 64'(b_resp), 64'(b_hold));
        end
        if (r_valid && r_ready) begin
          if (exp_r.size() == 0) begin
            chk("r_unexpected", 64'(r_valid), 64'd0);
          end else begin
            e = exp_r.pop_front();
            chk("r_data", r_data, e.d);
            chk("r_resp", 64'(r_resp), 64'(e.resp));
          end
        end
        if (b_valid && b_ready) begin
          if (exp_b.size() == 0) begin
            chk("b_unexpected", 64'(b_valid), 64'd0);
          end else begin
            eb = exp_b.pop_front();
            chk("b_resp", 64'(b_resp), 64'(eb));
          end
        end
        r_prev = r_valid;
        b_prev = b_valid;
      end
    end
  end

  initial begin
    r_exp_t e;
    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_r_valid", 64'(r_valid), 64'd0);
    chk("rst_b_valid", 64'(b_valid), 64'd0);
    chk("rst_w_ready", 64'(w_ready), 64'd0);
    chk("rst_r_data", r_data, 64'd0);
    chk("rst_r_resp", 64'(r_resp), 64'd0);
    chk("rst_b_resp", 64'(b_resp), 64'd0);
    chk("rst_ar_ready", 64'(ar_ready), 64'd0);
    chk("rst_aw_ready", 64'(aw_ready), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Basic write/read and boundary entries
    wr(17'h10008, 64'hDEAD_BEEF_0123_4567, 2'b00, 0);
    rd(17'h10008, 64'hDEAD_BEEF_0123_4567, 2'b00, 0);
    wr(17'h10000, 64'h1111_2222_3333_4444, 2'b00, 0);
    wr(17'h107F8, 64'hAAAA_BBBB_CCCC_DDDD, 2'b00, 0);
    rd(17'h10000, 64'h1111_2222_3333_4444, 2'b00, 0);
    rd(17'h107F8, 64'hAAAA_BBBB_CCCC_DDDD, 2'b00, 0);

    // Illegal addresses: above range, below range, misaligned
    rd(17'h10800, 64'd0, 2'b10, 0);
    rd(17'h0FFF8, 64'd0, 2'b10, 0);
    rd(17'h10004, 64'd0, 2'b10, 0);
    wr(17'h10800, 64'h5555_6666_7777_8888, 2'b10, 0);
    rd(17'h10000, 64'h1111_2222_3333_4444, 2'b00, 0);
    rd(17'h107F8, 64'hAAAA_BBBB_CCCC_DDDD, 2'b00, 0);

    // Backpressure for 10 cycles on R and B
    rd(17'h10008, 64'hDEAD_BEEF_0123_4567, 2'b00, 10);
    wr(17'h10010, 64'h0F0F_F0F0_1234_5678, 2'b00, 10);
    rd(17'h10010, 64'h0F0F_F0F0_1234_5678, 2'b00, 0);

    // Simultaneous AR and AW: read first, AW accepted in the IDLE cycle after R handshake
    e.d = 64'hDEAD_BEEF_0123_4567;
    e.resp = 2'b00;
    exp_r.push_back(e);
    exp_b.push_back(2'b00);
    ar_valid = 1'b1;
    ar_addr  = 17'h10008;
    aw_valid = 1'b1;
    aw_addr  = 17'h10018;
    @(negedge clk);
    chk("sim_ar_ready", 64'(ar_ready), 64'd1);
    chk("sim_aw_ready", 64'(aw_ready), 64'd0);
    @(posedge clk); #1;
    ar_valid = 1'b0;
    wait_on(3, "sim_r_valid");
    chk("sim_aw_wait", 64'(aw_ready), 64'd0);
    @(posedge clk); #1;
    r_ready = 1'b1;
    @(negedge clk);
    chk("sim_aw_in_r_hs", 64'(aw_ready), 64'd0);
    @(posedge clk); #1;
    r_ready = 1'b0;
    @(negedge clk);
    chk("sim_aw_after_r", 64'(aw_ready), 64'd1);
    @(posedge clk); #1;
    aw_valid = 1'b0;
    w_valid  = 1'b1;
    w_data   = 64'hCAFE_F00D_0000_0018;
    wait_on(1, "sim_w_ready");
    @(posedge clk); #1;
    w_valid = 1'b0;
    wait_on(4, "sim_b_valid");
    @(posedge clk); #1;
    b_ready = 1'b1;
    @(posedge clk); #1;
    b_ready = 1'b0;
    rd(17'h10018, 64'hCAFE_F00D_0000_0018, 2'b00, 0);

    // Reset during RD_WAIT abandons the read
    ar_valid = 1'b1;
    ar_addr  = 17'h10000;
    wait_on(2, "mid_ar_ready");
    @(posedge clk); #1;
    ar_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("mid_ar_ready_rst", 64'(ar_ready), 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("mid_r_valid", 64'(r_valid), 64'd0);
    chk("mid_ar_ready_rst2", 64'(ar_ready), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mid_ar_ready_after", 64'(ar_ready), 64'd1);
    @(posedge clk); #1;
    rd(17'h10000, 64'h1111_2222_3333_4444, 2'b00, 0);
    rd(17'h107F8, 64'hAAAA_BBBB_CCCC_DDDD, 2'b00, 0);

    // LAT=0 instance: valid rises one edge after the handshake edge
    z_aw_valid = 1'b1;
    z_aw_addr  = 17'h10020;
    @(negedge clk);
    chk("z_aw_ready", 64'(z_aw_ready), 64'd1);
    @(posedge clk); #1;
    z_aw_valid = 1'b0;
    z_w_valid  = 1'b1;
    z_w_data   = 64'h0123_4567_89AB_CDEF;
    @(negedge clk);
    chk("z_w_ready", 64'(z_w_ready), 64'd1);
    @(posedge clk); #1;
    z_w_valid = 1'b0;
    @(negedge clk);
    chk("z_b_early", 64'(z_b_valid), 64'd0);
    @(negedge clk);
    chk("z_b_valid", 64'(z_b_valid), 64'd1);
    chk("z_b_resp", 64'(z_b_resp), 64'd0);
    @(posedge clk); #1;
    z_b_ready = 1'b1;
    @(posedge clk); #1;
    z_b_ready = 1'b0;
    z_ar_valid = 1'b1;
    z_ar_addr  = 17'h10020;
    @(negedge clk);
    chk("z_ar_ready", 64'(z_ar_ready), 64'd1);
    @(posedge clk); #1;
    z_ar_valid = 1'b0;
    @(negedge clk);
    chk("z_r_early", 64'(z_r_valid), 64'd0);
    @(negedge clk);
    chk("z_r_valid", 64'(z_r_valid), 64'd1);
    chk("z_r_data", z_r_data, 64'h0123_4567_89AB_CDEF);
    chk("z_r_resp", 64'(z_r_resp), 64'd0);
    @(posedge clk); #1;
    z_r_ready = 1'b1;
    @(posedge clk); #1;
    z_r_ready = 1'b0;

    repeat (3) @(posedge clk);
    chk("r_queue_empty", 64'(exp_r.size()), 64'd0);
    chk("b_queue_empty", 64'(exp_b.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi_lite_dram_responder.md
Name: axi_lite_dram_responder

Overview:
- Synthesizable AXI4-Lite-style slave memory. It is the responder end of the DRAM channel driven by the bridge master: AR/R/AW/W/B channels, 64-bit data, 17-bit byte addresses.
- Serves as a cycle-accurate, configurable-latency DRAM model for bridge/BEV integration and for FPGA prototyping, where the behavioural DRAM model cannot be used.
- Handles one transaction at a time.

Parameters:
- ADDR_W, 17, address width in bits.
- DATA_W, 64, data width in bits (one entry = 8 bytes).
- BASE_ADDR, 17'h10000, byte address of entry 0.
- DEPTH, 256, number of 64-bit entries.
- LAT, 4, extra wait cycles before R/B valid (0..15).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- ar_valid  in  1  read address valid
- ar_addr  in  ADDR_W  read byte address
- ar_ready  out  1  read address ready
- r_valid  out  1  read data valid
- r_data  out  DATA_W  read data
- r_resp  out  2  read response: 2'b00 OKAY, 2'b10 SLVERR
- r_ready  in  1  master ready for read data
- aw_valid  in  1  write address valid
- aw_addr  in  ADDR_W  write byte address
- aw_ready  out  1  write address ready
- w_valid  in  1  write data valid
- w_data  in  DATA_W  write data
- w_ready  out  1  write data ready
- b_valid  out  1  write response valid
- b_resp  out  2  write response, same encoding as r_resp
- b_ready  in  1  master ready for write response

Behaviour:
- Reset: one clk and reset are fixed; rst is synchronous, active-high. On a rst edge, FSM goes to IDLE and the wait counter clears.
  - Reset values: r_valid=0, b_valid=0, w_ready=0, r_data=0, r_resp=0, b_resp=0.
  - ar_ready and aw_ready are low while rst is high.
  - Memory array is NOT reset; contents are retained across rst and are undefined at power-up.
- Address decode: address is legal iff BASE_ADDR <= addr < BASE_ADDR+8*DEPTH and addr[2:0]==0.
  - Index = (addr-BASE_ADDR)>>3.
  - Illegal address: response SLVERR, r_data=0, write discarded.
- FSM states: IDLE, RD_WAIT, RD_RESP, WR_DATA, WR_WAIT, WR_RESP.
- IDLE:
  - ar_ready=1.
  - aw_ready=!ar_valid (combinational); a read wins over a simultaneous write, and the write stays pending.
  - AR handshake: latch the address, load counter with LAT, go to RD_WAIT.
  - AW handshake: latch the address, go to WR_DATA.
  - ar_ready and aw_ready are 0 in every state other than IDLE.
- RD_WAIT:
  - Counter decrements each cycle.
  - When the counter is 0, register r_data/r_resp from memory and set r_valid; go to RD_RESP.
  - With LAT=0, r_valid is high in the cycle immediately after the AR handshake. In general r_valid rises LAT+1 cycles after the AR handshake cycle.
- RD_RESP:
  - r_valid, r_data and r_resp are held stable until r_ready=1.
  - On the handshake, r_valid drops next cycle and the FSM returns to IDLE.
  - No new AR is accepted in the handshake cycle.
- WR_DATA:
  - w_ready=1.
  - On W handshake: write w_data to memory at that edge if the address is legal, load counter with LAT, set w_ready=0, go to WR_WAIT.
  - W data arriving before AW is not accepted (w_ready stays low outside WR_DATA).
- WR_WAIT: counts down as in RD_WAIT. At 0, set b_valid and b_resp, go to WR_RESP.
- WR_RESP: b_valid and b_resp are held until b_ready. On the handshake, return to IDLE.
- Read-after-write: a read issued after a write's B handshake returns the new data.
- Reset mid-transaction: the transaction is abandoned with no response. A write whose W handshake already occurred stays committed; a write without a W handshake is not performed.
- Valid signals never drop without a handshake, except under rst.

Test Plan:
- Basic write/read, LAT=4:
  - Stimulus: AW 17'h10008, then W 64'hDEAD_BEEF_0123_4567.
  - Response: b_valid rises 5 cycles after the W handshake with b_resp=00.
  - Stimulus: AR 17'h10008.
  - Response: r_valid rises 5 cycles after AR with r_data=64'hDEAD_BEEF_0123_4567, r_resp=00.
- Simultaneous ar_valid and aw_valid in IDLE:
  - Response: ar_ready=1, aw_ready=0. The read completes first, then the AW is accepted in the IDLE cycle after the R handshake.
- Backpressure:
  - Stimulus: r_ready held low for 10 cycles.
  - Response: r_valid and r_data stay constant for all 10 cycles and the FSM stays in RD_RESP. The same check applies to b_ready/b_valid.
- Boundaries:
  - Write/read at 17'h10000 (entry 0) and 17'h107F8 (entry 255): OKAY with correct data.
  - AR 17'h10800, 17'h0FFF8 or 17'h10004: r_resp=10, r_data=0.
  - Write to 17'h10800: b_resp=10, and memory is unchanged (verified by reading back entry 0 and entry 255).
- LAT=0 build: r_valid is high in the cycle directly after the AR handshake; b_valid is high in the cycle after the W handshake.
- Reset mid-read:
  - Stimulus: assert rst during RD_WAIT.
  - Response: the next cycle shows r_valid=0, ar_ready=0 while rst is high, and ar_ready=1 after rst falls. Previously written data reads back unchanged.
